// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 icode, status and register-index definitions
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_t;

  localparam logic [3:0] REG_RSP  = 4'd4;
  localparam logic [3:0] REG_NONE = 4'd15;

  function automatic logic is_mem_icode(input logic [3:0] ic);
    return ic inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
  endfunction

  // ret/popq address the stack through the old %rsp carried on valA
  function automatic logic addr_from_vala(input logic [3:0] ic);
    return ic inside {I_RET, I_POPQ};
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// rtl/y86_regfile.sv - architectural register file, two read ports, E/M write ports
module y86_regfile
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15
) (
  input  logic              clk,
  input  logic [3:0]        src_a,
  input  logic [3:0]        src_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic [DATA_W-1:0] rsp_val,
  input  logic              we_e,
  input  logic [3:0]        dst_e,
  input  logic [DATA_W-1:0] val_e,
  input  logic              we_m,
  input  logic [3:0]        dst_m,
  input  logic [DATA_W-1:0] val_m
);

  logic [DATA_W-1:0] regs [NREGS];

  function automatic logic in_range(input logic [3:0] idx);
    return (idx != REG_NONE) && (int'(idx) < NREGS);
  endfunction

  // M is written last so it overrides E when both target the same register
  always_ff @(posedge clk) begin
    if (we_e && in_range(dst_e)) regs[dst_e] <= val_e;
    if (we_m && in_range(dst_m)) regs[dst_m] <= val_m;
  end

  assign rd_a    = in_range(src_a) ? regs[src_a] : '0;
  assign rd_b    = in_range(src_b) ? regs[src_b] : '0;
  assign rsp_val = regs[REG_RSP];

endmodule

// File: rtl/y86_mem_wb_unit.sv
// rtl/y86_mem_wb_unit.sv - SEQ Y86-64 memory/write-back/PC stage; Y86_RETIRE_COUNT_EN enables retired counter
module y86_mem_wb_unit
  import y86_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                MEM_DEPTH = 256,
  parameter int                MEM_LAT   = 1,
  parameter int                NREGS     = 15,
  parameter logic [DATA_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valC,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valP,
  input  logic              cnd,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] rdA,
  output logic [DATA_W-1:0] rdB,
  output logic [DATA_W-1:0] rsp_val,
  output logic [DATA_W-1:0] pc,
  output logic [1:0]        stat,
  output logic [31:0]       retired
);

  localparam int MEM_IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_COMMIT, S_HALT} state_t;

  state_t            state_q;
  logic              in_ready_q;
  logic [DATA_W-1:0] pc_q;
  stat_t             stat_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [3:0]        icode_q, ra_q, rb_q;
  logic [DATA_W-1:0] vala_q, valc_q, vale_q, valp_q, valm_q;
  logic              cnd_q;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [DATA_W-1:0] mem_addr, mem_wdata, next_pc;
  logic [MEM_IDX_W-1:0] mem_idx;
  logic              addr_bad, mem_we;
  logic              we_e, we_m;
  logic [3:0]        dst_e, dst_m;

  // ifun is resolved upstream into cnd; nothing here depends on it
  logic unused_ifun;
  assign unused_ifun = ^ifun;

  assign mem_addr  = addr_from_vala(icode_q) ? vala_q : vale_q;
  assign addr_bad  = mem_addr >= DATA_W'(MEM_DEPTH);
  assign mem_idx   = mem_addr[MEM_IDX_W-1:0];
  assign mem_wdata = (icode_q == I_CALL) ? valp_q : vala_q;
  assign mem_we    = !rst && (state_q == S_MEM) && !addr_bad && (cnt_q == '0) &&
                     (icode_q inside {I_RMMOVQ, I_PUSHQ, I_CALL});

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

  always_comb begin
    dst_e = REG_NONE;
    dst_m = REG_NONE;
    if ((icode_q == I_IRMOVQ) || (icode_q == I_OPQ) || ((icode_q == I_RRMOVQ) && cnd_q))
      dst_e = rb_q;
    else if (icode_q inside {I_CALL, I_RET, I_PUSHQ, I_POPQ})
      dst_e = REG_RSP;
    if ((icode_q == I_MRMOVQ) || (icode_q == I_POPQ))
      dst_m = ra_q;
  end

  always_comb begin
    next_pc = valp_q;
    if ((icode_q == I_CALL) || ((icode_q == I_JXX) && cnd_q))
      next_pc = valc_q;
    else if (icode_q == I_RET)
      next_pc = valm_q;
  end

  // reset during COMMIT must not let the register writes land
  assign we_e = !rst && (state_q == S_COMMIT);
  assign we_m = we_e;

  y86_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk     (clk),
    .src_a   (srcA),
    .src_b   (srcB),
    .rd_a    (rdA),
    .rd_b    (rdB),
    .rsp_val (rsp_val),
    .we_e    (we_e),
    .dst_e   (dst_e),
    .val_e   (vale_q),
    .we_m    (we_m),
    .dst_m   (dst_m),
    .val_m   (valm_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b1;
      pc_q       <= RESET_PC;
      stat_q     <= STAT_AOK;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            icode_q    <= icode;
            ra_q       <= rA;
            rb_q       <= rB;
            vala_q     <= valA;
            valc_q     <= valC;
            vale_q     <= valE;
            valp_q     <= valP;
            cnd_q      <= cnd;
            in_ready_q <= 1'b0;
            if (is_mem_icode(icode)) begin
              state_q <= S_MEM;
              cnt_q   <= CNT_W'(MEM_LAT - 1);
            end else if (icode == I_HALT) begin
              stat_q  <= STAT_HLT;
              state_q <= S_HALT;
            end else if (icode > I_POPQ) begin
              stat_q  <= STAT_INS;
              state_q <= S_HALT;
            end else begin
              state_q <= S_COMMIT;
            end
          end
        end
        S_MEM: begin
          if (addr_bad) begin
            stat_q  <= STAT_ADR;
            state_q <= S_HALT;
          end else if (cnt_q == '0) begin
            valm_q  <= mem[mem_idx];
            state_q <= S_COMMIT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_COMMIT: begin
          pc_q       <= next_pc;
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef Y86_RETIRE_COUNT_EN
  logic [31:0] retired_q;
  always_ff @(posedge clk) begin
    if (rst)
      retired_q <= '0;
    else if (state_q == S_COMMIT)
      retired_q <= retired_q + 32'd1;
  end
  assign retired = retired_q;
`else
  assign retired = '0;
`endif

  assign in_ready = in_ready_q;
  assign pc       = pc_q;
  assign stat     = stat_q;

endmodule
